// File: rtl/bit_scan_sequencer.sv
// Walks a latched 16-bit operand through the external bit tester one bit per cycle,
// producing a find-first index and a match count for the write-back path.
module bit_scan_sequencer #(
  parameter int WIDTH    = 16,
  parameter int LAST_BIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic             MODE,
  input  logic             POL,
  output logic [WIDTH-1:0] A_OUT,
  output logic [3:0]       BS,
  input  logic             F,
  output logic             BUSY,
  output logic             DONE,
  output logic             FOUND,
  output logic [3:0]       IDX,
  output logic [4:0]       CNT,
  output logic [1:0]       state_dbg
);

  // Handshake: START is a one-cycle request with no ready signal. It is taken only
  // while BUSY and DONE are both low (IDLE); requests in any other cycle are dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BS = 4'(LAST_BIT);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [3:0]       bs_q, bs_n;
  logic             mode_q, mode_n;
  logic             pol_q, pol_n;
  logic             found_q, found_n;
  logic [3:0]       idx_q, idx_n;
  logic [4:0]       cnt_q, cnt_n;
  logic             hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      bs_q    <= '0;
      mode_q  <= 1'b0;
      pol_q   <= 1'b0;
      found_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      bs_q    <= bs_n;
      mode_q  <= mode_n;
      pol_q   <= pol_n;
      found_q <= found_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
    end
  end

  assign hit = (F == pol_q);

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    bs_n    = bs_q;
    mode_n  = mode_q;
    pol_n   = pol_q;
    found_n = found_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        bs_n = '0;
        if (START) begin
          a_n     = A_IN;
          mode_n  = MODE;
          pol_n   = POL;
          found_n = 1'b0;
          idx_n   = '0;
          cnt_n   = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          cnt_n = cnt_q + 5'd1;
          if (!found_q) begin
            idx_n   = bs_q;
            found_n = 1'b1;
          end
        end
        // BS freezes on the terminating bit so it never wraps past the last index.
        if (!mode_q && hit) begin
          state_n = FIN;
        end else if (bs_q == LAST_BS) begin
          state_n = FIN;
        end else begin
          bs_n = bs_q + 4'd1;
        end
      end
      FIN: begin
        state_n = IDLE;
        bs_n    = '0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign A_OUT     = a_q;
  assign BS        = bs_q;
  assign BUSY      = (state_q == SCAN);
  assign DONE      = (state_q == FIN);
  assign FOUND     = found_q;
  assign IDX       = idx_q;
  assign CNT       = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: doc/bit_scan_sequencer.md
Name: bit_scan_sequencer

Overview:
- Sequential controller placed directly upstream of the 16-bit bit-test unit.
- Latches a 16-bit operand and drives that operand plus a bit-select (BS) into the bit tester one bit per cycle.
- Samples the tester's single-bit result F, and from it produces a first-match index and a match count for the processor's find-first-set / population-count instructions.
- Sits between the ALU operand bus and the bit-test unit; the result registers feed the register-file write-back mux.

Parameters:
WIDTH, 16, operand width; fixed at 16 to match the bit tester (BS is 4 bits).
LAST_BIT, 15, final bit index scanned.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
START  input  1  one-cycle request to begin a scan; honoured only in IDLE.
A_IN  input  16  operand to scan; sampled on the accepted START edge.
MODE  input  1  0 = find-first (stop at first match), 1 = full count (scan all 16 bits).
POL  input  1  match polarity: 1 = match set bits, 0 = match clear bits.
A_OUT  output  16  latched operand, wired to the bit tester A input.
BS  output  4  bit-select, wired to the bit tester BS input.
F  input  1  bit tester result for the current A_OUT/BS (combinational, same cycle).
BUSY  output  1  high while scanning.
DONE  output  1  one-cycle pulse when results are valid.
FOUND  output  1  at least one match occurred.
IDX  output  4  index of the lowest matching bit; 0 if none.
CNT  output  5  number of matching bits scanned (0..16).

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - A_OUT = 0, BS = 0, BUSY = 0, DONE = 0, FOUND = 0, IDX = 0, CNT = 0.
  - Reset asserted mid-scan aborts the scan; no DONE pulse is issued.
- States: IDLE, SCAN, FIN.
- IDLE:
  - BS held at 0, BUSY = 0.
  - START=1 at an edge:
    - A_OUT <= A_IN; MODE and POL are latched.
    - FOUND, IDX and CNT are cleared; BS <= 0.
    - Next state = SCAN.
- SCAN:
  - BUSY = 1.
  - Each cycle: hit = (F == POL_latched), using the current BS.
  - On hit: CNT <= CNT+1.
  - On hit with FOUND == 0: IDX <= BS, FOUND <= 1.
  - Find-first mode (MODE 0), hit: next state = FIN (no further increment).
  - Otherwise, BS == 15: next state = FIN.
  - Otherwise: BS <= BS+1.
  - BS must not wrap past 15.
- FIN:
  - DONE = 1 for exactly one cycle; BUSY = 0.
  - Next state = IDLE; BS returns to 0.
- Latency (cycles from the START edge to the edge at which DONE is first high):
  - Find-first with a match at bit k: k+1.
  - Find-first with no match: 16.
  - Count mode: always 16.
- In find-first mode, CNT is 1 when FOUND is set and 0 otherwise.
- Results (FOUND, IDX, CNT, A_OUT) hold after DONE until the next accepted START or reset.
- START while in SCAN or FIN is ignored; it is not queued.
- A_IN, MODE and POL changes during a scan have no effect.
- All-match count of 16 must be representable: CNT is 5 bits, with no overflow.

Test Plan:
1. Reset during a count-mode scan at BS=7 -> all outputs 0 immediately, state IDLE, no DONE; a following START scans normally.
2. MODE=0, POL=1, A_IN=16'h0020 -> DONE at cycle 6 after START, FOUND=1, IDX=5, CNT=1; BS sequence 0..5.
3. MODE=0, POL=1, A_IN=16'h0000 -> DONE at cycle 16, FOUND=0, IDX=0, CNT=0, BS stops at 15 (no wrap).
4. MODE=1, POL=1, A_IN=16'hFFFF -> DONE at cycle 16, CNT=16, IDX=0, FOUND=1. Then MODE=1, POL=0, A_IN=16'hF0F0 -> CNT=8, IDX=0.
5. MODE=1, POL=1, A_IN=16'h8400 -> CNT=2, IDX=10, FOUND=1. A START pulse asserted at cycle 4 with A_IN=16'h0001 is ignored; results are unchanged and BUSY stays high until FIN.
6. Back-to-back: START asserted in the cycle DONE is high is ignored. START one cycle later is accepted, and the new scan clears the prior FOUND/IDX/CNT.
